// File: rtl/depar_pkt_cache_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : depar_pkt_cache_pkg                                             |
// | Purpose  : Shared definitions for the deparser packet cache: default       |
// |            widths, stored-entry width helper and write-FSM state encoding. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package depar_pkt_cache_pkg;

  // Default geometry of the cache
  localparam int DFLT_AXIS_DATA_WIDTH  = 256;
  localparam int DFLT_AXIS_TUSER_WIDTH = 128;
  localparam int DFLT_FIFO_BITS_WIDTH  = 8;

  // Write-side state: no packet open, packet being stored, packet being discarded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_DROP = 2'd2
  } wr_state_t;

  // One stored beat is {tlast, tuser, tkeep, tdata}
  function automatic int entry_width(input int data_w, input int tuser_w);
    return 1 + tuser_w + (data_w / 8) + data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/depar_cache_ram.sv
// +----------------------------------------------------------------------------+
// | Module   : depar_cache_ram                                                 |
// | Purpose  : Simple dual-port synchronous RAM, one write port and one read   |
// |            port with a registered output (1-cycle read latency). The read  |
// |            output holds its value while re is low.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module depar_cache_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 417
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Storage write and registered read; the cache never reads and writes one address together
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/depar_pkt_cache.sv
// +----------------------------------------------------------------------------+
// | Module   : depar_pkt_cache                                                 |
// | Purpose  : Store-and-forward packet buffer in front of the deparser. Only  |
// |            complete packets are exposed on the FWFT pkt_fifo_* interface;  |
// |            a packet that cannot fit is dropped whole.                      |
// | Options  : DEPAR_CACHE_STATS_EN adds pkt_in_cnt / pkt_drop_cnt outputs.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module depar_pkt_cache
  import depar_pkt_cache_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = DFLT_AXIS_DATA_WIDTH,
  parameter int C_AXIS_TUSER_WIDTH = DFLT_AXIS_TUSER_WIDTH,
  parameter int C_FIFO_BITS_WIDTH  = DFLT_FIFO_BITS_WIDTH
) (
  input  logic                            axis_clk,
  input  logic                            areset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    pkt_fifo_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  pkt_fifo_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   pkt_fifo_tuser,
  output logic                            pkt_fifo_tlast,
  output logic                            pkt_fifo_empty,
  input  logic                            pkt_fifo_rd_en
`ifdef DEPAR_CACHE_STATS_EN
  ,
  output logic [31:0]                     pkt_in_cnt,
  output logic [31:0]                     pkt_drop_cnt
`endif
);

  localparam int KEEP_W  = C_AXIS_DATA_WIDTH / 8;
  localparam int ENTRY_W = entry_width(C_AXIS_DATA_WIDTH, C_AXIS_TUSER_WIDTH);
  localparam int PTR_W   = C_FIFO_BITS_WIDTH + 1;
  localparam int DEPTH   = 1 << C_FIFO_BITS_WIDTH;
  localparam int CNT_W   = C_FIFO_BITS_WIDTH + 2;

  // Write side
  logic              ready_q;
  wr_state_t         state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  commit_ptr;
  logic              commit_evt;
  logic [PTR_W-1:0]  used;
  logic              accept;
  logic              store;
  logic              overflow;
  logic [ENTRY_W-1:0] wr_entry;

  // Read side
  logic [PTR_W-1:0]  rd_ptr;
  logic              ram_vld;
  logic              head_vld;
  logic              head_load;
  logic              issue;
  logic              pop;
  logic [ENTRY_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  pkt_cnt;

  assign s_axis_tready = ready_q;

  // used counts beats still held in the RAM; beats already prefetched into the
  // RAM output or head register have been copied out, so their slots are free.
  assign used     = wr_ptr - rd_ptr;
  assign accept   = s_axis_tvalid & ready_q;
  assign store    = accept & (state != ST_DROP) & (used != PTR_W'(DEPTH));
  assign overflow = accept & (state != ST_DROP) & (used == PTR_W'(DEPTH));
  assign wr_entry = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

  // Prefetch only inside the committed region. A read is blocked only when both
  // the RAM output and the head are occupied and the head is not being popped.
  assign pop       = pkt_fifo_rd_en & ~pkt_fifo_empty;
  assign head_load = ram_vld & (~head_vld | pop);
  assign issue     = (rd_ptr != commit_ptr) & ~(ram_vld & head_vld & ~pop);

  // The head is only offered once its packet is counted as committed
  assign pkt_fifo_empty = ~(head_vld & (pkt_cnt != '0));

  depar_cache_ram #(
    .ADDR_W (C_FIFO_BITS_WIDTH),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk   (axis_clk),
    .we    (store),
    .waddr (wr_ptr[C_FIFO_BITS_WIDTH-1:0]),
    .wdata (wr_entry),
    .re    (issue),
    .raddr (rd_ptr[C_FIFO_BITS_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  // Write FSM: speculative wr_ptr, commit on tlast, rewind and discard on overflow
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      ready_q    <= 1'b0;
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      commit_evt <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      commit_evt <= store & s_axis_tlast;
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (s_axis_tlast) begin
          commit_ptr <= wr_ptr + PTR_W'(1);
        end
      end else if (overflow) begin
        wr_ptr <= commit_ptr;
      end
      case (state)
        ST_IDLE, ST_WR: begin
          // An overflowing tlast beat already ends its packet, so no DROP phase follows
          if (overflow) begin
            state <= s_axis_tlast ? ST_IDLE : ST_DROP;
          end else if (store) begin
            state <= s_axis_tlast ? ST_IDLE : ST_WR;
          end
        end
        ST_DROP: begin
          if (accept && s_axis_tlast) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FWFT read pipeline: RAM output stage feeding the head register
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      rd_ptr         <= '0;
      ram_vld        <= 1'b0;
      head_vld       <= 1'b0;
      pkt_fifo_tdata <= '0;
      pkt_fifo_tkeep <= '0;
      pkt_fifo_tuser <= '0;
      pkt_fifo_tlast <= 1'b0;
    end else begin
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      ram_vld <= issue | (ram_vld & ~head_load);
      if (head_load) begin
        head_vld       <= 1'b1;
        pkt_fifo_tlast <= ram_rdata[ENTRY_W-1];
        pkt_fifo_tuser <= ram_rdata[ENTRY_W-2 -: C_AXIS_TUSER_WIDTH];
        pkt_fifo_tkeep <= ram_rdata[C_AXIS_DATA_WIDTH +: KEEP_W];
        pkt_fifo_tdata <= ram_rdata[C_AXIS_DATA_WIDTH-1:0];
      end else if (pop) begin
        head_vld <= 1'b0;
      end
    end
  end

  // Committed-but-unpopped packet count; simultaneous commit and last pop cancel
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      pkt_cnt <= '0;
    end else begin
      case ({commit_evt, pop & pkt_fifo_tlast})
        2'b10:   pkt_cnt <= pkt_cnt + CNT_W'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CNT_W'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

`ifdef DEPAR_CACHE_STATS_EN
  // Per-packet statistics, counted at the commit or drop decision
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      pkt_in_cnt   <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (store && s_axis_tlast) begin
        pkt_in_cnt <= pkt_in_cnt + 32'd1;
      end
      if (overflow) begin
        pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_depar_pkt_cache.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_depar_pkt_cache                                              |
// | Purpose  : Directed self-checking bench for depar_pkt_cache.               |
// | Options  : DEPAR_CACHE_STATS_EN also checks the statistics counters.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_depar_pkt_cache;

  typedef logic [416:0] entry_t;

  logic         clk = 1'b0;
  logic         areset;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [255:0] f_tdata;
  logic [31:0]  f_tkeep;
  logic [127:0] f_tuser;
  logic         f_tlast;
  logic         f_empty;
  logic         rd_en;
`ifdef DEPAR_CACHE_STATS_EN
  logic [31:0]  pkt_in_cnt;
  logic [31:0]  pkt_drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  entry_t exp_q[$];
  entry_t rcv_q[$];
  int     stamp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  depar_pkt_cache dut (
    .axis_clk       (clk),
    .areset         (areset),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tuser   (s_tuser),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .pkt_fifo_tdata (f_tdata),
    .pkt_fifo_tkeep (f_tkeep),
    .pkt_fifo_tuser (f_tuser),
    .pkt_fifo_tlast (f_tlast),
    .pkt_fifo_empty (f_empty),
    .pkt_fifo_rd_en (rd_en)
`ifdef DEPAR_CACHE_STATS_EN
    ,
    .pkt_in_cnt     (pkt_in_cnt),
    .pkt_drop_cnt   (pkt_drop_cnt)
`endif
  );

  // Record every beat popped at the coming rising edge
  always @(negedge clk) begin
    if (!areset && rd_en && !f_empty) begin
      rcv_q.push_back({f_tlast, f_tuser, f_tkeep, f_tdata});
      stamp_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t mk(input int pid, input int bi, input bit last, input logic [31:0] keep);
    logic [15:0] w;
    w  = {pid[7:0], bi[7:0]};
    mk = {last, 96'h0, pid[15:0], bi[15:0], keep, {16{w}}};
  endfunction

  task automatic drive_beat(input entry_t e);
    s_tvalid = 1'b1;
    s_tlast  = e[416];
    s_tuser  = e[415:288];
    s_tkeep  = e[287:256];
    s_tdata  = e[255:0];
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int pid, input int n, input bit deliver);
    entry_t e;
    for (int b = 0; b < n; b++) begin
      e = mk(pid, b, (b == n - 1), (b == n - 1) ? 32'h0000_0FFF : 32'hFFFF_FFFF);
      if (deliver) exp_q.push_back(e);
      drive_beat(e);
    end
  endtask

  // Pop until the expected beats arrive (bounded), then a few more cycles to catch extras
  task automatic drain(input string tag, input int budget);
    int k;
    k     = 0;
    rd_en = 1'b1;
    while (rcv_q.size() < exp_q.size() && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (6) @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk({tag, "_count"}, rcv_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      chk({tag, "_beat"}, rcv_q[i], exp_q[i]);
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    rcv_q.delete();
    stamp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    entry_t e;
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    rd_en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", s_tready, 0);
    chk("rst_empty", f_empty, 1);
    chk("rst_tdata", f_tdata, 0);
    areset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("tready_up", s_tready, 1);
`ifdef DEPAR_CACHE_STATS_EN
    chk("rst_in_cnt", pkt_in_cnt, 0);
    chk("rst_drop_cnt", pkt_drop_cnt, 0);
`endif

    // Scenario 1: single-beat packet, head appears exactly 2 cycles after tlast
    e = mk(1, 0, 1'b1, 32'hFFFF_FFFF);
    exp_q.push_back(e);
    drive_beat(e);
    chk("s1_empty_c0", f_empty, 1);
    @(posedge clk); #1;
    chk("s1_empty_c1", f_empty, 1);
    @(posedge clk); #1;
    chk("s1_empty_c2", f_empty, 0);
    chk("s1_head", {f_tlast, f_tuser, f_tkeep, f_tdata}, e);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk("s1_empty_pop", f_empty, 1);
    drain("s1", 10);
    clear_q();

    // Scenario 2: three 4-beat packets back-to-back with continuous reads
    rd_en = 1'b1;
    send_pkt(2, 4, 1'b1);
    send_pkt(3, 4, 1'b1);
    send_pkt(4, 4, 1'b1);
    drain("s2", 40);
    if (stamp_q.size() >= 12) begin
      for (int i = 1; i < 12; i++) chk("s2_contig", stamp_q[i] - stamp_q[0], i);
    end
    clear_q();

    // Scenario 3: 255 committed beats, then a 4-beat packet that cannot fit
    for (int p = 0; p < 51; p++) send_pkt(10 + p, 5, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("s3_empty_before", f_empty, 0);
    send_pkt(99, 4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("s3_empty_after", f_empty, 0);
`ifdef DEPAR_CACHE_STATS_EN
    chk("s3_drop_cnt", pkt_drop_cnt, 1);
    chk("s3_in_cnt", pkt_in_cnt, 55);
`endif
    drain("s3", 400);
    clear_q();
    send_pkt(100, 3, 1'b1);
    drain("s3_next", 40);
    clear_q();

    // Scenario 4: oversized packet is dropped, the next one passes
    send_pkt(200, 300, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("s4_empty", f_empty, 1);
`ifdef DEPAR_CACHE_STATS_EN
    chk("s4_drop_cnt", pkt_drop_cnt, 2);
`endif
    send_pkt(201, 2, 1'b1);
    drain("s4", 40);
    clear_q();

    // Scenario 5: last pop of A coincides with B's commit count update
    send_pkt(300, 2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("s5_a_ready", f_empty, 0);
    for (int b = 0; b < 3; b++) begin
      e = mk(301, b, (b == 2), 32'hFFFF_FFFF);
      exp_q.push_back(e);
      if (b == 2) rd_en = 1'b1;
      drive_beat(e);
    end
    drain("s5", 20);
    if (stamp_q.size() >= 5) begin
      chk("s5_a_contig", stamp_q[1] - stamp_q[0], 1);
      chk("s5_b_latency", stamp_q[2] - stamp_q[1], 2);
      chk("s5_b_contig", stamp_q[4] - stamp_q[2], 2);
    end
    clear_q();

    // Scenario 6: reset in the middle of a 6-beat packet
    for (int b = 0; b < 3; b++) drive_beat(mk(400, b, 1'b0, 32'hFFFF_FFFF));
    areset = 1'b1;
    @(posedge clk); #1;
    chk("s6_rst_tready", s_tready, 0);
    chk("s6_rst_empty", f_empty, 1);
    chk("s6_rst_tdata", f_tdata, 0);
    @(posedge clk); #1;
    areset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("s6_tready", s_tready, 1);
    chk("s6_empty", f_empty, 1);
`ifdef DEPAR_CACHE_STATS_EN
    chk("s6_in_cnt", pkt_in_cnt, 0);
    chk("s6_drop_cnt", pkt_drop_cnt, 0);
`endif
    send_pkt(401, 2, 1'b1);
    drain("s6", 40);
    clear_q();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
